// File: rtl/la_oai22_pipe_pkg.sv
// la_logic_pkg: constants shared by the la_* datapath cells.
//   la_mode_e     - per-beat function select for the 2x2 and-or cells
//   LA_DEPTH_MAX  - upper bound on pipeline depth for pipelined cells
package la_logic_pkg;

    typedef enum logic [1:0] {
        LA_MODE_OAI22 = 2'b00,
        LA_MODE_OA22  = 2'b01,
        LA_MODE_AOI22 = 2'b10,
        LA_MODE_AO22  = 2'b11
    } la_mode_e;

    localparam int unsigned LA_DEPTH_MAX = 8;

endpackage

// File: rtl/la_oai22_pipe_if.sv
// la_oai22_pipe_if: streaming bus of la_oai22_pipe.
//   mode, a0, a1, b0, b1, in_valid / in_ready : input beat and handshake
//   z, out_valid / out_ready                  : result beat and handshake
//   slave  modport : the pipeline itself
//   master modport : producer/consumer around it
interface la_oai22_pipe_if #(
    parameter int W = 1
);
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [W-1:0] b0;
    logic [W-1:0] b1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;

    modport slave (
        input  mode, in_valid, a0, a1, b0, b1, out_ready,
        output in_ready, out_valid, z
    );

    modport master (
        output mode, in_valid, a0, a1, b0, b1, out_ready,
        input  in_ready, out_valid, z
    );
endinterface

// File: rtl/la_pipe_stage.sv
// la_pipe_stage: one valid + W-bit data register of a ready/valid pipeline.
//   clk, nreset           : clock, asynchronous active-low clear
//   in_valid, in_data     : beat offered by the previous stage
//   in_ready              : this stage loads on the coming edge
//   out_valid, out_data   : beat held by this stage
//   out_ready             : the next stage loads on the coming edge
module la_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    // An empty slot always loads, which is what collapses bubbles.
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            // A bubble moving in leaves the old word in place.
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/la_oai22_pipe.sv
// la_oai22_pipe: W-bit OAI22/OA22/AOI22/AO22 (selected per beat by mode)
// followed by DEPTH ready/valid register stages with bubble collapsing.
//   clk    : clock, rising edge
//   nreset : asynchronous active-low reset, clears every stage
//   bus    : la_oai22_pipe_if slave (operands, mode, handshakes, result z)
// Parameters: W lane count, DEPTH stages (1..LA_DEPTH_MAX), PROP passed to
// technology mapping only.
module la_oai22_pipe
    import la_logic_pkg::*;
#(
    parameter int    W     = 1,
    parameter int    DEPTH = 2,
    parameter string PROP  = "DEFAULT"
) (
    input  logic               clk,
    input  logic               nreset,
    la_oai22_pipe_if.slave     bus
);

    logic [W-1:0]            fn;
    logic [DEPTH:0]          v_chain;
    logic [DEPTH:0][W-1:0]   d_chain;
    logic [DEPTH+1:1]        load;

    // PROP only steers technology mapping; nothing is built from it.
    if (PROP == "") begin : g_prop_none
    end

    always_comb begin
        fn = '0;
        case (bus.mode)
            LA_MODE_OAI22: fn = ~((bus.a0 | bus.a1) & (bus.b0 | bus.b1));
            LA_MODE_OA22:  fn =   (bus.a0 | bus.a1) & (bus.b0 | bus.b1);
            LA_MODE_AOI22: fn = ~((bus.a0 & bus.a1) | (bus.b0 & bus.b1));
            LA_MODE_AO22:  fn =   (bus.a0 & bus.a1) | (bus.b0 & bus.b1);
            default:       fn = '0;
        endcase
    end

    assign v_chain[0]   = bus.in_valid;
    assign d_chain[0]   = fn;
    assign load[DEPTH+1] = bus.out_ready;

    // Ready ripples combinationally from out_ready back to stage 1.
    for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
        la_pipe_stage #(
            .W (W)
        ) u_stage (
            .clk       (clk),
            .nreset    (nreset),
            .in_valid  (v_chain[i-1]),
            .in_data   (d_chain[i-1]),
            .in_ready  (load[i]),
            .out_valid (v_chain[i]),
            .out_data  (d_chain[i]),
            .out_ready (load[i+1])
        );
    end

    // Cleared stages look empty, so in_ready is masked during reset.
    assign bus.in_ready  = load[1] & nreset;
    assign bus.out_valid = v_chain[DEPTH];
    assign bus.z         = d_chain[DEPTH];

endmodule

// File: doc/la_oai22_pipe.md
Name: la_oai22_pipe

Overview:
- Parametrised, pipelined successor to the single-bit OAI22 cell.
- Computes a W-bit vector of one of four 2x2 and-or functions, selected per beat by a mode input.
- Carries results through DEPTH register stages under a valid/ready handshake with per-stage stall and bubble collapsing.
- Used where wide OAI/AOI reductions must be retimed and back-pressured inside streaming datapaths.

Parameters:
- W, 1, vector width of every operand and of the result.
- DEPTH, 2, number of register stages, legal range 1..8; sets latency in cycles.
- PROP, "DEFAULT", implementation property string passed through to technology mapping; no functional effect.

Ports:
- clk  input  1  clock, all state on rising edge.
- nreset  input  1  asynchronous active-low reset.
- mode  input  2  function select, sampled with the beat.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a0  input  W  operand a0.
- a1  input  W  operand a1.
- b0  input  W  operand b0.
- b1  input  W  operand b1.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- z  output  W  result of the oldest beat.

Behaviour:
- Clocking and reset, fixed for this block: one clock, clk; reset nreset is asynchronous and active-low.
- Mode encoding, bitwise per lane:
  - 00 OAI22: ~((a0|a1)&(b0|b1))
  - 01 OA22: (a0|a1)&(b0|b1)
  - 10 AOI22: ~((a0&a1)|(b0&b1))
  - 11 AO22: (a0&a1)|(b0&b1)
- Computation is combinational ahead of stage 1. Only the W-bit result is registered, never the operands.
- Transfer occurs on any edge where valid and ready are both high.
- Pipeline: stages s[1..DEPTH], each holding a valid bit v[i] and a data word d[i].
  - z = d[DEPTH]; out_valid = v[DEPTH].
  - Stage i may load when ~v[i] or stage i+1 loads. The last stage loads when ~v[DEPTH] or out_ready.
  - in_ready = stage 1 may load, and is forced 0 while nreset is low.
- Ready propagates combinationally from out_ready through all stages. When the pipeline is full and out_ready=1, in_ready=1 in the same cycle.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+DEPTH-1, i.e. DEPTH cycles after presentation, if no stalls occur.
- Throughput: one beat per cycle with out_ready held high.
- Stall: while out_valid=1 and out_ready=0, z and out_valid hold stable. Upstream stages keep filling empty slots (bubble collapsing).
- Full condition: all v[i]=1 and out_ready=0 gives in_ready=0. At most DEPTH beats are in flight.
- Ordering: strict FIFO order; no beat is dropped or duplicated.
- A stage with v[i]=0 holds its old d[i]. z is undefined-free (held) but meaningful only when out_valid=1.
- Reset: nreset low asynchronously clears all v[i] and d[i] to 0. As a result out_valid=0, z=0 and in_ready=0.
- Reset mid-operation: all in-flight beats are discarded, and nothing emerges after release.
- First acceptance is possible on the first edge after nreset deasserts.
- in_valid=0 while in_ready=1 inserts a bubble. Changing mode between beats is legal, and each beat uses its own mode.

Decomposition:
- Shared package la_logic_pkg holds:
  - the mode constants LA_MODE_OAI22=2'b00, LA_MODE_OA22=2'b01, LA_MODE_AOI22=2'b10, LA_MODE_AO22=2'b11;
  - the legal DEPTH bound constant (8).
- One sub-module, la_pipe_stage (parameter W): a valid plus W-bit data register with load enable, async active-low clear, and ready-in/ready-out.
- la_oai22_pipe contains the mode function and a generate loop of DEPTH la_pipe_stage instances.

Test Plan:
- Reset, W=4, DEPTH=2:
  - Hold nreset=0 with in_valid=1 -> in_ready=0, out_valid=0, z=4'b0000.
  - Release nreset -> in_ready=1 before the next edge.
- OAI22 latency, W=4, DEPTH=2: a0=0011, a1=0101, b0=1000, b1=0001, mode=00, out_ready=1 -> out_valid=1 after the second edge, z=1110.
- Per-beat mode: same operands, back-to-back modes 00,01,10,11 -> z sequence 1110, 0001, 1110, 0001 on four consecutive cycles.
- Backpressure: out_ready=0, offer beats Q1..Q3 -> Q1,Q2 accepted, in_ready=0 for Q3, z holds Q1 value. Raise out_ready -> Q3 accepted in the same cycle; outputs Q1,Q2,Q3 in order, no gaps.
- Bubble collapse, DEPTH=3: one beat stalled in the last stage with stages 1-2 empty and out_ready=0 -> in_ready stays 1 for two more beats, then drops.
- Reset mid-flight: 2 beats in flight, pulse nreset low mid-cycle -> out_valid=0 and z=0 immediately; after release, no output beat appears without new input.
